// File: rtl/arb_2to1.sv
// Two-requester round-robin arbiter that feeds a one-word registered output stage.
// Optional feature: define ARB_2TO1_LOCK_EN to add lock0/lock1, which hold a grant across words.
module arb_2to1 #(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         req0,
  input  logic         req1,
  input  logic [n-1:0] q0,
  input  logic [n-1:0] q1,
`ifdef ARB_2TO1_LOCK_EN
  input  logic         lock0,
  input  logic         lock1,
`endif
  output logic         ack0,
  output logic         ack1,
  output logic         sel,
  output logic         gnt,
  output logic [n-1:0] d,
  output logic         d_valid,
  input  logic         d_ready
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e       state_q, state_d;
  logic         last_q, last_d;
  logic [n-1:0] d_q, d_d;
  logic         valid_q, valid_d;
  logic         space;
  logic         hold0, hold1;

`ifdef ARB_2TO1_LOCK_EN
  assign hold0 = lock0;
  assign hold1 = lock1;
`else
  assign hold0 = 1'b0;
  assign hold1 = 1'b0;
`endif

  // The output register can accept a word if it is empty or being drained this cycle.
  assign space = !valid_q || d_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          if (req0 && req1) begin
            state_d = last_q ? StGrant0 : StGrant1;
          end else if (req0) begin
            state_d = StGrant0;
          end else if (req1) begin
            state_d = StGrant1;
          end
        end
      end
      StGrant0: begin
        if (!req0 || (ack0 && !hold0)) begin
          state_d = StIdle;
        end
      end
      StGrant1: begin
        if (!req1 || (ack1 && !hold1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt  = 1'b0;
    sel  = 1'b0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    unique case (state_q)
      StGrant0: begin
        gnt  = 1'b1;
        ack0 = req0 && space;
      end
      StGrant1: begin
        gnt  = 1'b1;
        sel  = 1'b1;
        ack1 = req1 && space;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= 1'b1;
      d_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      d_q     <= d_d;
      valid_q <= valid_d;
    end
  end

  // An accepted word overrides a same-cycle drain, so d_valid stays high with the new word.
  always_comb begin
    d_d     = d_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (ack0) begin
      d_d     = q0;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (ack1) begin
      d_d     = q1;
      valid_d = 1'b1;
      last_d  = 1'b1;
    end else if (valid_q && d_ready) begin
      valid_d = 1'b0;
    end
  end

  assign d       = d_q;
  assign d_valid = valid_q;

endmodule

// File: tb/tb_arb_2to1.sv
// Bench for arb_2to1: directed scenarios plus random traffic, checked against a
// transaction-level model; output words go through a scoreboard queue.
module tb_arb_2to1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] q0 = 8'h00;
  logic [7:0] q1 = 8'h00;
  logic       lock0 = 1'b0;
  logic       lock1 = 1'b0;
  logic       d_ready = 1'b0;
  logic       ack0, ack1, sel, gnt, d_valid;
  logic [7:0] d;

  always #5 clk = ~clk;

  arb_2to1 #(.n(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req0    (req0),
    .req1    (req1),
    .q0      (q0),
    .q1      (q1),
`ifdef ARB_2TO1_LOCK_EN
    .lock0   (lock0),
    .lock1   (lock1),
`endif
    .ack0    (ack0),
    .ack1    (ack1),
    .sel     (sel),
    .gnt     (gnt),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner = -1 when nobody holds the grant, else the granted requester.
  int         owner = -1;
  bit         mlast = 1'b1;
  bit         mvalid = 1'b0;
  bit         e_ack0 = 1'b0;
  bit         e_ack1 = 1'b0;
  logic [7:0] exp_q[$];
  bit         cap_en = 1'b0;
  logic [7:0] cap[$];

  always @(negedge clk) begin : model_p
    bit space, a0, a1, lk0, lk1;
    if (!rst) begin
      owner  = -1;
      mlast  = 1'b1;
      mvalid = 1'b0;
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      exp_q.delete();
    end else begin
`ifdef ARB_2TO1_LOCK_EN
      lk0 = lock0;
      lk1 = lock1;
`else
      lk0 = 1'b0;
      lk1 = 1'b0;
`endif
      space = !mvalid || d_ready;
      a0 = (owner == 0) && req0 && space;
      a1 = (owner == 1) && req1 && space;
      chk("ack0", ack0, a0);
      chk("ack1", ack1, a1);
      chk("gnt", gnt, owner != -1);
      chk("sel", sel, owner == 1);
      chk("d_valid", d_valid, mvalid);
      e_ack0 = a0;
      e_ack1 = a1;
      if (a0) begin
        exp_q.push_back(q0);
        mvalid = 1'b1;
        mlast  = 1'b0;
      end else if (a1) begin
        exp_q.push_back(q1);
        mvalid = 1'b1;
        mlast  = 1'b1;
      end else if (d_ready) begin
        mvalid = 1'b0;
      end
      if (owner == -1) begin
        if (en) begin
          if (req0 && req1) owner = mlast ? 0 : 1;
          else if (req0) owner = 0;
          else if (req1) owner = 1;
        end
      end else if (owner == 0) begin
        if (!req0 || (a0 && !lk0)) owner = -1;
      end else begin
        if (!req1 || (a1 && !lk1)) owner = -1;
      end
    end
  end

  // Scoreboard monitor: every presented word must match the oldest accepted word.
  always @(negedge clk) begin
    if (rst && d_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL data: d_valid with no expected word, got %0h", d);
      end else begin
        chk("data", d, exp_q[0]);
        if (d_ready) begin
          if (cap_en) cap.push_back(d);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_step();
    if (req0 && e_ack0) begin
      if ($urandom_range(1) == 1) q0 = 8'($urandom);
      else req0 = 1'b0;
    end else if (req0 && $urandom_range(19) == 0) begin
      req0 = 1'b0;
    end else if (!req0 && $urandom_range(2) == 0) begin
      req0 = 1'b1;
      q0   = 8'($urandom);
    end
    if (req1 && e_ack1) begin
      if ($urandom_range(1) == 1) q1 = 8'($urandom);
      else req1 = 1'b0;
    end else if (req1 && $urandom_range(19) == 0) begin
      req1 = 1'b0;
    end else if (!req1 && $urandom_range(2) == 0) begin
      req1 = 1'b1;
      q1   = 8'($urandom);
    end
    en      = ($urandom_range(9) != 0);
    d_ready = ($urandom_range(2) != 0);
    lock0   = $urandom_range(1) == 1;
    lock1   = $urandom_range(1) == 1;
  endtask

  initial begin
    bit found;
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_ack1", ack1, 1'b0);
    chk("rst_sel", sel, 1'b0);
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_d", d, 8'h00);
    chk("rst_d_valid", d_valid, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Tie: alternating A5/5A, first to requester 0
    en = 1'b1; d_ready = 1'b1; req0 = 1'b1; req1 = 1'b1; q0 = 8'hA5; q1 = 8'h5A;
    cap.delete();
    cap_en = 1'b1;
    repeat (9) tick();
    cap_en = 1'b0;
    chk("tie_count", cap.size(), 4);
    if (cap.size() == 4) begin
      chk("tie_w0", cap[0], 8'hA5);
      chk("tie_w1", cap[1], 8'h5A);
      chk("tie_w2", cap[2], 8'hA5);
      chk("tie_w3", cap[3], 8'h5A);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();

    // Backpressure on requester 0
    d_ready = 1'b0; req1 = 1'b1; q1 = 8'h77;
    tick();
    tick();
    req1 = 1'b0; req0 = 1'b1; q0 = 8'h3C;
    tick();
    tick();
    #2;
    chk("bp_gnt", gnt, 1'b1);
    chk("bp_sel", sel, 1'b0);
    chk("bp_ack0_held", ack0, 1'b0);
    chk("bp_d_old", d, 8'h77);
    d_ready = 1'b1;
    #1;
    chk("bp_ack0_now", ack0, 1'b1);
    tick();
    chk("bp_d_new", d, 8'h3C);
    chk("bp_d_valid", d_valid, 1'b1);

    // Withdrawal from GRANT1
    req0 = 1'b0; req1 = 1'b1; q1 = 8'hC3; d_ready = 1'b0;
    tick();
    chk("wd_gnt1", gnt, 1'b1);
    chk("wd_sel1", sel, 1'b1);
    req1 = 1'b0;
    tick();
    chk("wd_idle", gnt, 1'b0);
    chk("wd_d_kept", d, 8'h3C);
    req0 = 1'b1; q0 = 8'hE7; d_ready = 1'b1;
    tick();
    chk("wd_gnt0", gnt, 1'b1);
    chk("wd_sel0", sel, 1'b0);
    tick();
    req0 = 1'b0;
    chk("wd_d_e7", d, 8'hE7);
    tick();

    // Enable low blocks grants
    en = 1'b0; req0 = 1'b1; q0 = 8'h42;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("en0_gnt", gnt, 1'b0);
    end
    en = 1'b1;
    tick();
    chk("en1_gnt", gnt, 1'b1);
    tick();
    req0 = 1'b0;
    repeat (2) tick();

    // Reset in GRANT1 with a held word
    d_ready = 1'b0; req1 = 1'b1; q1 = 8'h99;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (owner == 1 && mvalid) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL mid_rst_setup: GRANT1 with d_valid not reached, got 0 expected 1");
    end
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_d", d, 8'h00);
    chk("mid_rst_d_valid", d_valid, 1'b0);
    chk("mid_rst_sel", sel, 1'b0);
    chk("mid_rst_gnt", gnt, 1'b0);
    chk("mid_rst_ack1", ack1, 1'b0);
    req1 = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;

    // First tie after reset goes to requester 0
    d_ready = 1'b1; req0 = 1'b1; req1 = 1'b1; q0 = 8'h11; q1 = 8'h22;
    cap.delete();
    cap_en = 1'b1;
    repeat (3) tick();
    cap_en = 1'b0;
    chk("post_rst_count", cap.size() > 0, 1'b1);
    if (cap.size() > 0) chk("post_rst_tie", cap[0], 8'h11);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();

`ifdef ARB_2TO1_LOCK_EN
    // Lock: back-to-back words 1..4, then requester 1
    lock0 = 1'b1; req0 = 1'b1; req1 = 1'b1; q0 = 8'd1; q1 = 8'hBB; d_ready = 1'b1;
    cap.delete();
    cap_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (e_ack0) begin
        if (q0 == 8'd4) begin
          req0  = 1'b0;
          found = 1'b1;
        end else begin
          q0 = q0 + 8'd1;
          if (q0 == 8'd4) lock0 = 1'b0;
        end
      end
    end
    repeat (4) tick();
    cap_en = 1'b0;
    req1 = 1'b0;
    chk("lock_count", cap.size() >= 5, 1'b1);
    if (cap.size() >= 5) begin
      chk("lock_w0", cap[0], 8'd1);
      chk("lock_w1", cap[1], 8'd2);
      chk("lock_w2", cap[2], 8'd3);
      chk("lock_w3", cap[3], 8'd4);
      chk("lock_next", cap[4], 8'hBB);
    end
    repeat (3) tick();
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_step();
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; d_ready = 1'b1; en = 1'b1;
    repeat (4) tick();
    chk("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
